// File: rtl/mm_seq_ctrl_if.sv
// mm_seq_ctrl_if: host/array-facing signal bundle for the matrix-multiply
// sequencer.
//
// Signals:
//   start      host -> ctrl  job request, only honoured while idle
//   outReady   host -> ctrl  downstream accepts the current psum
//   busy       ctrl -> host  job in progress
//   done       ctrl -> host  one-cycle completion pulse
//   psumClr    ctrl -> array clear every PE accumulator
//   rowEn      ctrl -> array per-row A-FIFO pop / operand valid
//   colEn      ctrl -> array per-column B-FIFO pop / operand valid
//   outValid   ctrl -> host  psum selection valid
//   drainEn    ctrl -> array psum accepted, advance output mux
//   outRow     ctrl -> array row index of psum being drained
//   outCol     ctrl -> array column index of psum being drained
//   lastCycles ctrl -> host  start-to-done cycle count of the last job
//
// Modports: master is the host/array side, slave is the sequencer.
interface mm_seq_ctrl_if #(
  parameter int Width    = 9,
  parameter int Height   = 4,
  parameter int CntWidth = 16
);
  localparam int RowW = (Height > 1) ? $clog2(Height) : 1;
  localparam int ColW = (Width > 1) ? $clog2(Width) : 1;

  logic                start;
  logic                outReady;
  logic                busy;
  logic                done;
  logic                psumClr;
  logic [Height-1:0]   rowEn;
  logic [Width-1:0]    colEn;
  logic                outValid;
  logic                drainEn;
  logic [RowW-1:0]     outRow;
  logic [ColW-1:0]     outCol;
  logic [CntWidth-1:0] lastCycles;

  modport master (
    output start, outReady,
    input  busy, done, psumClr, rowEn, colEn, outValid, drainEn,
           outRow, outCol, lastCycles
  );

  modport slave (
    input  start, outReady,
    output busy, done, psumClr, rowEn, colEn, outValid, drainEn,
           outRow, outCol, lastCycles
  );
endinterface

// File: rtl/mm_seq_ctrl.sv
// mm_seq_ctrl: sequencer for an output-stationary Height x Width
// matrix-multiply array computing C = A[Height x Size] * B[Size x Width].
// A job clears the accumulators, streams skewed operand pop enables,
// waits out the MAC pipeline, then drains the psums in row-major order.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, abandons any job in flight
//   bus  mm_seq_ctrl_if.slave (start/outReady in, control and status out)
module mm_seq_ctrl #(
  parameter int Width      = 9,
  parameter int Height     = 4,
  parameter int Size       = 9,
  parameter int MacLatency = 1,
  parameter int CntWidth   = 16
) (
  input  logic         clk,
  input  logic         rst,
  mm_seq_ctrl_if.slave bus
);
  localparam int RowW      = (Height > 1) ? $clog2(Height) : 1;
  localparam int ColW      = (Width > 1) ? $clog2(Width) : 1;
  localparam int StreamLen = Size + Height + Width - 2;
  localparam int TW        = $clog2(StreamLen + 1);
  localparam int WaitW     = (MacLatency > 1) ? $clog2(MacLatency) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_WAIT,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [TW-1:0]       t_cnt;
  logic [WaitW-1:0]    wait_cnt;
  logic [RowW-1:0]     row_idx;
  logic [ColW-1:0]     col_idx;
  logic [CntWidth-1:0] cyc;
  logic [CntWidth-1:0] last_cycles;
  logic                drain_en;
  logic                last_beat;
  logic                stream_end;
  logic                wait_end;

  // outReady -> drainEn is the only combinational input-to-output path.
  assign drain_en   = (state == ST_DRAIN) && bus.outReady;
  assign last_beat  = (row_idx == RowW'(Height - 1)) && (col_idx == ColW'(Width - 1));
  assign stream_end = (t_cnt == TW'(StreamLen - 1));
  assign wait_end   = (MacLatency > 0) && (wait_cnt == WaitW'(MacLatency - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (bus.start) next_state = ST_CLEAR;
      ST_CLEAR:  next_state = ST_STREAM;
      ST_STREAM: if (stream_end) next_state = (MacLatency == 0) ? ST_DRAIN : ST_WAIT;
      ST_WAIT:   if (wait_end) next_state = ST_DRAIN;
      ST_DRAIN:  if (drain_en && last_beat) next_state = ST_DONE;
      ST_DONE:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Phase counters self-clear outside their own state so every entry
  // starts from zero without extra load logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_cnt       <= '0;
      wait_cnt    <= '0;
      row_idx     <= '0;
      col_idx     <= '0;
      cyc         <= '0;
      last_cycles <= '0;
    end else begin
      t_cnt    <= (state == ST_STREAM) ? t_cnt + 1'b1 : '0;
      wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;

      if (state != ST_DRAIN) begin
        row_idx <= '0;
        col_idx <= '0;
      end else if (drain_en) begin
        if (col_idx == ColW'(Width - 1)) begin
          col_idx <= '0;
          row_idx <= row_idx + 1'b1;
        end else begin
          col_idx <= col_idx + 1'b1;
        end
      end

      // cyc counts the CLEAR cycle as 1, so at DONE it holds the full job length.
      if (state == ST_IDLE) begin
        cyc <= bus.start ? CntWidth'(1) : '0;
      end else if (cyc != '1) begin
        cyc <= cyc + 1'b1;
      end

      if (state == ST_DONE) begin
        last_cycles <= cyc;
      end
    end
  end

  // Row r / column c is live for Size cycles starting at STREAM t = r / c,
  // giving the diagonal skew the systolic array expects.
  always_comb begin
    bus.busy       = (state != ST_IDLE);
    bus.done       = (state == ST_DONE);
    bus.psumClr    = (state == ST_CLEAR);
    bus.outValid   = (state == ST_DRAIN);
    bus.drainEn    = drain_en;
    bus.outRow     = (state == ST_DRAIN) ? row_idx : '0;
    bus.outCol     = (state == ST_DRAIN) ? col_idx : '0;
    bus.lastCycles = last_cycles;
    bus.rowEn      = '0;
    bus.colEn      = '0;
    if (state == ST_STREAM) begin
      for (int r = 0; r < Height; r++) begin
        bus.rowEn[r] = (int'(t_cnt) >= r) && (int'(t_cnt) < r + Size);
      end
      for (int c = 0; c < Width; c++) begin
        bus.colEn[c] = (int'(t_cnt) >= c) && (int'(t_cnt) < c + Size);
      end
    end
  end
endmodule
